// File: rtl/tcdm_outstanding_tracker.sv
// Reorder-ID allocator and latency tracker between a TCDM request source and the interconnect.
// Caps in-flight requests, timestamps each one and matches out-of-order responses by ID.
module tcdm_outstanding_tracker #(
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned IdWidth        = $clog2(MaxOutstanding),
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned LatWidth       = 16,
  parameter int unsigned CntWidth       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  // upstream request
  input  logic                   up_req_valid_i,
  output logic                   up_req_ready_o,
  input  logic [AddrWidth-1:0]   up_req_addr_i,
  input  logic                   up_req_wen_i,
  input  logic [DataWidth-1:0]   up_req_wdata_i,
  input  logic [DataWidth/8-1:0] up_req_be_i,
  // downstream request
  output logic                   dn_req_valid_o,
  input  logic                   dn_req_ready_i,
  output logic [AddrWidth-1:0]   dn_req_addr_o,
  output logic                   dn_req_wen_o,
  output logic [DataWidth-1:0]   dn_req_wdata_o,
  output logic [DataWidth/8-1:0] dn_req_be_o,
  output logic [IdWidth-1:0]     dn_req_id_o,
  // downstream response
  input  logic                   dn_resp_valid_i,
  output logic                   dn_resp_ready_o,
  input  logic [IdWidth-1:0]     dn_resp_id_i,
  input  logic [DataWidth-1:0]   dn_resp_rdata_i,
  // upstream response
  output logic                   up_resp_valid_o,
  input  logic                   up_resp_ready_i,
  output logic [DataWidth-1:0]   up_resp_rdata_o,
  output logic [IdWidth-1:0]     up_resp_id_o,
  output logic [LatWidth-1:0]    up_resp_latency_o,
  // status and statistics
  output logic [IdWidth:0]       outstanding_o,
  output logic                   idle_o,
  output logic [CntWidth-1:0]    num_completed_o,
  output logic [CntWidth-1:0]    latency_sum_o,
  output logic [LatWidth-1:0]    latency_max_o,
  output logic                   err_o
);

  localparam logic [IdWidth:0] MaxCnt = (IdWidth+1)'(MaxOutstanding);

  logic [MaxOutstanding-1:0] busy_q, busy_d;
  logic [IdWidth:0]          outstanding_q, outstanding_d;
  logic [LatWidth-1:0]       cycle_q;
  logic [LatWidth-1:0]       ts_q [MaxOutstanding];
  logic [CntWidth-1:0]       num_completed_q, num_completed_d;
  logic [CntWidth-1:0]       latency_sum_q, latency_sum_d;
  logic [LatWidth-1:0]       latency_max_q, latency_max_d;
  logic                      err_q, err_d;

  logic                      full;
  logic [IdWidth-1:0]        alloc_id;
  logic                      req_hs;
  logic                      resp_hs;
  logic                      resp_busy;
  logic                      resp_match;
  logic                      resp_spurious;
  logic [LatWidth-1:0]       resp_lat;
  logic [CntWidth:0]         sum_ext;

  // Request path: combinational pass-through gated by the in-flight cap.
  assign full           = (outstanding_q == MaxCnt);
  assign dn_req_valid_o = up_req_valid_i & ~full;
  assign up_req_ready_o = dn_req_ready_i & ~full;
  assign dn_req_addr_o  = up_req_addr_i;
  assign dn_req_wen_o   = up_req_wen_i;
  assign dn_req_wdata_o = up_req_wdata_i;
  assign dn_req_be_o    = up_req_be_i;
  assign dn_req_id_o    = alloc_id;
  assign req_hs         = dn_req_valid_o & dn_req_ready_i;

  // Lowest free index wins; descending scan lets the lowest overwrite last.
  always_comb begin
    alloc_id = '0;
    for (int i = MaxOutstanding - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_id = IdWidth'(i);
      end
    end
  end

  // Response path: combinational pass-through.
  assign up_resp_valid_o = dn_resp_valid_i;
  assign dn_resp_ready_o = up_resp_ready_i;
  assign up_resp_id_o    = dn_resp_id_i;
  assign up_resp_rdata_o = dn_resp_rdata_i;

  assign resp_hs       = dn_resp_valid_i & up_resp_ready_i;
  assign resp_busy     = busy_q[dn_resp_id_i];
  assign resp_match    = resp_hs & resp_busy;
  assign resp_spurious = resp_hs & ~resp_busy;

  // Modular subtraction handles counter wrap; unknown IDs report zero.
  always_comb begin
    resp_lat = '0;
    if (resp_busy) begin
      resp_lat = cycle_q - ts_q[dn_resp_id_i];
    end
  end
  assign up_resp_latency_o = resp_lat;

  // An allocated ID was free and a matched ID was busy, so the two never collide.
  always_comb begin
    busy_d        = busy_q;
    outstanding_d = outstanding_q;
    if (req_hs) begin
      busy_d[alloc_id] = 1'b1;
    end
    if (resp_match) begin
      busy_d[dn_resp_id_i] = 1'b0;
    end
    if (req_hs && !resp_match) begin
      outstanding_d = outstanding_q + (IdWidth+1)'(1);
    end else if (!req_hs && resp_match) begin
      outstanding_d = outstanding_q - (IdWidth+1)'(1);
    end
  end

  assign sum_ext = {1'b0, latency_sum_q} + (CntWidth+1)'(resp_lat);

  always_comb begin
    num_completed_d = num_completed_q;
    latency_sum_d   = latency_sum_q;
    latency_max_d   = latency_max_q;
    err_d           = err_q | resp_spurious;
    if (resp_match) begin
      if (num_completed_q != '1) begin
        num_completed_d = num_completed_q + CntWidth'(1);
      end
      latency_sum_d = sum_ext[CntWidth] ? '1 : sum_ext[CntWidth-1:0];
      if (resp_lat > latency_max_q) begin
        latency_max_d = resp_lat;
      end
    end
    // Clear overrides any same-cycle update.
    if (clear_i) begin
      num_completed_d = '0;
      latency_sum_d   = '0;
      latency_max_d   = '0;
      err_d           = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q          <= '0;
      outstanding_q   <= '0;
      cycle_q         <= '0;
      num_completed_q <= '0;
      latency_sum_q   <= '0;
      latency_max_q   <= '0;
      err_q           <= 1'b0;
    end else begin
      busy_q          <= busy_d;
      outstanding_q   <= outstanding_d;
      cycle_q         <= cycle_q + LatWidth'(1);
      num_completed_q <= num_completed_d;
      latency_sum_q   <= latency_sum_d;
      latency_max_q   <= latency_max_d;
      err_q           <= err_d;
    end
  end

  // Timestamps are only meaningful while the ID is busy, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && req_hs) begin
      ts_q[alloc_id] <= cycle_q;
    end
  end

  assign outstanding_o   = outstanding_q;
  assign idle_o          = (outstanding_q == '0);
  assign num_completed_o = num_completed_q;
  assign latency_sum_o   = latency_sum_q;
  assign latency_max_o   = latency_max_q;
  assign err_o           = err_q;

`ifndef SYNTHESIS
  a_cap: assert property (@(posedge clk_i) disable iff (rst_i) outstanding_q <= MaxCnt);
  a_count: assert property (@(posedge clk_i) disable iff (rst_i)
    $countones(busy_q) == int'(outstanding_q));
`endif

endmodule

// File: tb/tb_tcdm_outstanding_tracker.sv
// Directed bench for tcdm_outstanding_tracker: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares every upstream response handshake.
module tb_tcdm_outstanding_tracker;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        up_req_valid = 1'b0;
  logic        up_req_ready;
  logic [31:0] up_req_addr = '0;
  logic        up_req_wen = 1'b0;
  logic [31:0] up_req_wdata = '0;
  logic [3:0]  up_req_be = '0;
  logic        dn_req_valid;
  logic        dn_req_ready = 1'b1;
  logic [31:0] dn_req_addr;
  logic        dn_req_wen;
  logic [31:0] dn_req_wdata;
  logic [3:0]  dn_req_be;
  logic [3:0]  dn_req_id;
  logic        dn_resp_valid = 1'b0;
  logic        dn_resp_ready;
  logic [3:0]  dn_resp_id = '0;
  logic [31:0] dn_resp_rdata = '0;
  logic        up_resp_valid;
  logic        up_resp_ready = 1'b1;
  logic [31:0] up_resp_rdata;
  logic [3:0]  up_resp_id;
  logic [15:0] up_resp_latency;
  logic [4:0]  outstanding;
  logic        idle;
  logic [31:0] num_completed;
  logic [31:0] latency_sum;
  logic [15:0] latency_max;
  logic        err;

  tcdm_outstanding_tracker #(
    .MaxOutstanding(16),
    .AddrWidth(32),
    .DataWidth(32),
    .LatWidth(16),
    .CntWidth(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .clear_i(clear_i),
    .up_req_valid_i(up_req_valid),
    .up_req_ready_o(up_req_ready),
    .up_req_addr_i(up_req_addr),
    .up_req_wen_i(up_req_wen),
    .up_req_wdata_i(up_req_wdata),
    .up_req_be_i(up_req_be),
    .dn_req_valid_o(dn_req_valid),
    .dn_req_ready_i(dn_req_ready),
    .dn_req_addr_o(dn_req_addr),
    .dn_req_wen_o(dn_req_wen),
    .dn_req_wdata_o(dn_req_wdata),
    .dn_req_be_o(dn_req_be),
    .dn_req_id_o(dn_req_id),
    .dn_resp_valid_i(dn_resp_valid),
    .dn_resp_ready_o(dn_resp_ready),
    .dn_resp_id_i(dn_resp_id),
    .dn_resp_rdata_i(dn_resp_rdata),
    .up_resp_valid_o(up_resp_valid),
    .up_resp_ready_i(up_resp_ready),
    .up_resp_rdata_o(up_resp_rdata),
    .up_resp_id_o(up_resp_id),
    .up_resp_latency_o(up_resp_latency),
    .outstanding_o(outstanding),
    .idle_o(idle),
    .num_completed_o(num_completed),
    .latency_sum_o(latency_sum),
    .latency_max_o(latency_max),
    .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] rdata;
    logic [15:0] lat;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    ts_m [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every upstream response handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst_i && up_resp_valid && up_resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: got id %0h, expected no response", up_resp_id);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_id", up_resp_id, e.id);
        check("resp_rdata", up_resp_rdata, e.rdata);
        check("resp_latency", up_resp_latency, e.lat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] exp_id, input logic [31:0] addr);
    up_req_valid = 1'b1;
    up_req_addr  = addr;
    up_req_wen   = addr[2];
    up_req_wdata = ~addr;
    up_req_be    = addr[7:4];
    #1;
    check("req_valid", dn_req_valid, 1);
    check("req_id", dn_req_id, exp_id);
    check("req_payload", {dn_req_addr, dn_req_wdata}, {addr, ~addr});
    check("req_ctl", {dn_req_wen, dn_req_be}, {addr[2], addr[7:4]});
    ts_m[exp_id] = cyc;
    step();
    up_req_valid = 1'b0;
  endtask

  // matched=0 marks a response for an ID the bench knows is free.
  task automatic respond(input logic [3:0] id, input logic [31:0] rdata, input bit matched);
    resp_t e;
    dn_resp_valid = 1'b1;
    dn_resp_id    = id;
    dn_resp_rdata = rdata;
    e.id    = id;
    e.rdata = rdata;
    e.lat   = matched ? 16'(cyc - ts_m[id]) : 16'd0;
    exp_q.push_back(e);
    step();
    dn_resp_valid = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int done, input int sum, input int mx);
    check({tag, "_completed"}, num_completed, 64'(done));
    check({tag, "_lat_sum"}, latency_sum, 64'(sum));
    check({tag, "_lat_max"}, latency_max, 64'(mx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    step();
    rst_i = 1'b0;
    #1;
    check("rst_outstanding", outstanding, 0);
    check("rst_idle", idle, 1);
    check("rst_err", err, 0);
    check_stats("rst", 0, 0, 0);
    check("rst_req_ready", up_req_ready, 1);
    check("resp_ready_pass", dn_resp_ready, 1);

    // Downstream backpressure reaches upstream ready but not valid.
    dn_req_ready = 1'b0;
    up_req_valid = 1'b1;
    #1;
    check("bp_up_ready", up_req_ready, 0);
    check("bp_dn_valid", dn_req_valid, 1);
    dn_req_ready = 1'b1;
    up_req_valid = 1'b0;
    step();

    // Single read with latency 4.
    issue(4'd0, 32'h0000_0040);
    check("single_outstanding", outstanding, 1);
    step();
    step();
    step();
    respond(4'd0, 32'hcafe_0001, 1'b1);
    check_stats("single", 1, 4, 4);
    check("single_idle", idle, 1);

    // Fill all 16 IDs.
    for (int i = 0; i < 16; i++) begin
      issue(4'(i), 32'h1000_0000 + 32'(i * 16));
    end
    check("fill_outstanding", outstanding, 16);
    check("fill_idle", idle, 0);
    up_req_valid = 1'b1;
    #1;
    check("full_up_ready", up_req_ready, 0);
    check("full_dn_valid", dn_req_valid, 0);
    respond(4'd3, 32'h0000_0003, 1'b1);
    check("after3_outstanding", outstanding, 15);
    issue(4'd3, 32'h2000_0000);
    check("refill_outstanding", outstanding, 16);

    // Response for ID 5 while a request waits: full blocks issue this cycle.
    up_req_valid = 1'b1;
    #1;
    check("simul_dn_valid", dn_req_valid, 0);
    respond(4'd5, 32'h0000_0005, 1'b1);
    issue(4'd5, 32'h3000_0000);
    check("simul_outstanding", outstanding, 16);

    for (int i = 0; i < 16; i++) begin
      respond(4'(i), 32'h5000_0000 + 32'(i), 1'b1);
    end
    check("drain_idle", idle, 1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check_stats("clear1", 0, 0, 0);

    // Out-of-order: issue 0,1,2; answer 2 (lat 3), 0 (lat 9), 1 (lat 12).
    issue(4'd0, 32'h4000_0000);
    issue(4'd1, 32'h4000_0010);
    issue(4'd2, 32'h4000_0020);
    step();
    step();
    respond(4'd2, 32'haaaa_0002, 1'b1);
    step();
    step();
    step();
    respond(4'd0, 32'haaaa_0000, 1'b1);
    step();
    step();
    step();
    respond(4'd1, 32'haaaa_0001, 1'b1);
    check_stats("ooo", 3, 24, 12);
    check("ooo_err", err, 0);
    check("ooo_idle", idle, 1);

    // Spurious response for free ID 7.
    issue(4'd0, 32'h6000_0000);
    respond(4'd7, 32'hdead_0007, 1'b0);
    check("spur_err", err, 1);
    check_stats("spur", 3, 24, 12);
    check("spur_outstanding", outstanding, 1);
    step();
    check("spur_sticky", err, 1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("clear_err", err, 0);
    check_stats("clear2", 0, 0, 0);
    check("clear_outstanding", outstanding, 1);

    // Clear beats a same-cycle matched response.
    clear_i = 1'b1;
    respond(4'd0, 32'hbeef_0000, 1'b1);
    clear_i = 1'b0;
    check_stats("clrmatch", 0, 0, 0);
    check("clrmatch_outstanding", outstanding, 0);

    // Reset mid-flight discards in-flight IDs.
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 32'h7000_0000 + 32'(i * 16));
    end
    check("mid_outstanding", outstanding, 4);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("post_rst_outstanding", outstanding, 0);
    check("post_rst_idle", idle, 1);
    respond(4'd1, 32'h0bad_0001, 1'b0);
    check("post_rst_err", err, 1);
    check("post_rst_outstanding2", outstanding, 0);
    check("post_rst_completed", num_completed, 0);
    issue(4'd0, 32'h8000_0000);
    check("post_rst_issue", outstanding, 1);

    step();
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcdm_outstanding_tracker.md
Name: tcdm_outstanding_tracker

Overview:
- Sits between a core-side TCDM request source (traffic generator or core LSU) and the address demux / TCDM interconnect.
- Allocates reorder IDs from a free list and caps the number of outstanding requests.
- Timestamps each request and matches out-of-order responses by ID.
- Produces per-response latency plus aggregate statistics (completed count, latency sum, max latency) for interconnect characterisation.

Parameters:
MaxOutstanding, 16, max in-flight requests; power of two, >= 2
IdWidth, $clog2(MaxOutstanding), derived reorder ID width; do not override
AddrWidth, 32, request address width
DataWidth, 32, data width; strobe width is DataWidth/8
LatWidth, 16, width of cycle counter, timestamps and latency values
CntWidth, 32, width of statistics counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
clear_i  in  1  synchronous clear of statistics and err_o only
up_req_valid_i  in  1  upstream request valid
up_req_ready_o  out  1  upstream request ready
up_req_addr_i  in  AddrWidth  request address
up_req_wen_i  in  1  write enable
up_req_wdata_i  in  DataWidth  write data
up_req_be_i  in  DataWidth/8  byte enables
dn_req_valid_o  out  1  downstream request valid
dn_req_ready_i  in  1  downstream request ready
dn_req_addr_o  out  AddrWidth  forwarded address
dn_req_wen_o  out  1  forwarded write enable
dn_req_wdata_o  out  DataWidth  forwarded write data
dn_req_be_o  out  DataWidth/8  forwarded byte enables
dn_req_id_o  out  IdWidth  allocated reorder ID
dn_resp_valid_i  in  1  downstream response valid
dn_resp_ready_o  out  1  downstream response ready
dn_resp_id_i  in  IdWidth  response reorder ID
dn_resp_rdata_i  in  DataWidth  response data
up_resp_valid_o  out  1  upstream response valid
up_resp_ready_i  in  1  upstream response ready
up_resp_rdata_o  out  DataWidth  response data
up_resp_id_o  out  IdWidth  response ID
up_resp_latency_o  out  LatWidth  latency of this response in cycles
outstanding_o  out  IdWidth+1  current in-flight count
idle_o  out  1  outstanding_o == 0
num_completed_o  out  CntWidth  matched responses since reset/clear
latency_sum_o  out  CntWidth  sum of matched latencies
latency_max_o  out  LatWidth  maximum matched latency
err_o  out  1  sticky: response received for an ID not in flight

Behaviour:
- Reset state (rst_i=1 on a clock edge): all IDs free; outstanding_o=0; idle_o=1; cycle counter=0; all stats=0; err_o=0. Reset mid-operation discards all in-flight state.
- Request path is combinational, zero latency:
  - full = (outstanding == MaxOutstanding)
  - dn_req_valid_o = up_req_valid_i & ~full
  - up_req_ready_o = dn_req_ready_i & ~full
  - Payload passes through unchanged.
  - dn_req_id_o = lowest-index free ID, taken from the registered free vector.
- Request handshake (dn_req_valid_o & dn_req_ready_i): the ID is marked busy, and ts[ID] = cycle counter. Reads and writes are both tracked, since every request returns a response.
- Cycle counter: LatWidth bits, free-running, wraps, increments every cycle while out of reset.
- Response path is combinational pass-through:
  - up_resp_valid_o = dn_resp_valid_i
  - dn_resp_ready_o = up_resp_ready_i
  - up_resp_id_o = dn_resp_id_i
  - up_resp_rdata_o = dn_resp_rdata_i
  - up_resp_latency_o = (cycle - ts[dn_resp_id_i]) mod 2^LatWidth
- Response handshake with ID busy:
  - Free the ID.
  - num_completed += 1, saturating at all-ones.
  - latency_sum += latency, zero-extended and saturating.
  - latency_max = max(latency_max, latency).
- Response handshake with ID free:
  - Set err_o.
  - Leave the free list and stats unchanged.
  - Force up_resp_latency_o to 0.
- Same-cycle alloc and free:
  - outstanding is unchanged.
  - A freed ID is not reallocated in the same cycle because allocation uses the registered vector.
  - A response for the ID being allocated in that cycle is an error, since that ID was free.
- Latency for a same-cycle request and response is impossible. The minimum matched latency is 1.
- Latencies >= 2^LatWidth alias modulo 2^LatWidth; this is accepted behaviour.
- clear_i zeroes num_completed, latency_sum, latency_max and err_o. It does not touch the free list or the cycle counter.
- clear_i and a matched response in the same cycle: clear wins, and the stats hold 0 afterwards.
- rst_i has priority over clear_i.

Test Plan:
- Single read: issue a request at cycle 5, dn_req_ready_i=1, return a response at cycle 9 -> dn_req_id_o=0, up_resp_latency_o=4, num_completed_o=1, latency_sum_o=4, latency_max_o=4, idle_o=1.
- Fill: 16 back-to-back requests with no responses -> IDs 0..15 in order, outstanding_o=16, 17th request sees up_req_ready_o=0 and dn_req_valid_o=0. A response for ID 3 then re-enables issue and the next ID is 3.
- Out-of-order: issue IDs 0,1,2; respond 2,0,1 with distinct delays -> each latency correct, latency_max_o = largest delay, no err_o.
- Simultaneous: with 16 outstanding, ID 5 responds while a request is pending in the same cycle -> no issue that cycle (full); issue next cycle gets ID 5, outstanding stays 16.
- Spurious response for free ID 7 -> err_o=1 sticky, up_resp_latency_o=0, stats unchanged. clear_i -> err_o=0 and stats=0 while outstanding_o is preserved.
- Reset mid-flight: 4 outstanding, pulse rst_i, then response ID 1 -> err_o=1, outstanding_o=0, num_completed_o=0.
